// File: rtl/rle_dec.sv
// Run-length decoder: expands {bit_id, count} run words into a serial bit
// stream packed LSB-first into bytes, with a final partial-byte flush.
module rle_dec #(
   parameter int CNT_W  = 23,
   parameter int BYTE_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              recv_ready,
   input  logic [CNT_W:0]    in_data,
   output logic              rd_req,
   input  logic              end_of_stream,
   input  logic              send_ready,
   output logic [BYTE_W-1:0] out_data,
   output logic              wr_req,
   output logic              done
);

   localparam int IDX_W = $clog2(BYTE_W + 1);

   typedef enum logic [3:0] {
      S_INIT,
      S_REQUEST,
      S_WAIT,
      S_READ,
      S_SHIFT,
      S_FLUSH,
      S_COUNT_DONE,
      S_WAIT_OUT,
      S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic              value_type_q, value_type_d;
   logic [CNT_W-1:0]  run_left_q, run_left_d;
   logic [BYTE_W-1:0] byte_buf_q, byte_buf_d;
   logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
   logic [BYTE_W-1:0] out_reg_q, out_reg_d;
   logic              flush_q, flush_d;
   logic              rd_req_q, rd_req_d;
   logic              wr_req_q, wr_req_d;
   logic              done_q, done_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_INIT;
         value_type_q <= 1'b0;
         run_left_q   <= '0;
         byte_buf_q   <= '0;
         bit_idx_q    <= '0;
         out_reg_q    <= '0;
         flush_q      <= 1'b0;
         rd_req_q     <= 1'b0;
         wr_req_q     <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         value_type_q <= value_type_d;
         run_left_q   <= run_left_d;
         byte_buf_q   <= byte_buf_d;
         bit_idx_q    <= bit_idx_d;
         out_reg_q    <= out_reg_d;
         flush_q      <= flush_d;
         rd_req_q     <= rd_req_d;
         wr_req_q     <= wr_req_d;
         done_q       <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_INIT:    state_d = S_REQUEST;
         S_REQUEST: begin
            // A pending word always wins over end_of_stream.
            if (recv_ready)
               state_d = S_WAIT;
            else if (end_of_stream)
               state_d = (bit_idx_q != '0) ? S_FLUSH : S_DONE;
         end
         S_WAIT:    state_d = S_READ;
         S_READ:    state_d = (in_data[CNT_W-1:0] == '0) ? S_REQUEST : S_SHIFT;
         S_SHIFT: begin
            if (bit_idx_q == IDX_W'(BYTE_W - 1))
               state_d = S_COUNT_DONE;
            else if (run_left_q == CNT_W'(1))
               state_d = S_REQUEST;
         end
         S_FLUSH:      state_d = S_COUNT_DONE;
         S_COUNT_DONE: if (send_ready) state_d = S_WAIT_OUT;
         S_WAIT_OUT: begin
            if (flush_q)
               state_d = S_DONE;
            else if (run_left_q != '0)
               state_d = S_SHIFT;
            else
               state_d = S_REQUEST;
         end
         S_DONE:  state_d = S_DONE;
         default: state_d = S_INIT;
      endcase
   end

   always_comb begin
      value_type_d = value_type_q;
      run_left_d   = run_left_q;
      byte_buf_d   = byte_buf_q;
      bit_idx_d    = bit_idx_q;
      out_reg_d    = out_reg_q;
      flush_d      = flush_q;
      rd_req_d     = 1'b0;
      wr_req_d     = 1'b0;
      done_d       = (state_d == S_DONE);
      case (state_q)
         S_INIT: begin
            run_left_d = '0;
            byte_buf_d = '0;
            bit_idx_d  = '0;
            flush_d    = 1'b0;
         end
         S_REQUEST: rd_req_d = recv_ready;
         S_READ: begin
            value_type_d = in_data[CNT_W];
            run_left_d   = in_data[CNT_W-1:0];
         end
         S_SHIFT: begin
            for (int unsigned i = 0; i < BYTE_W; i++)
               if (bit_idx_q == IDX_W'(i)) byte_buf_d[i] = value_type_q;
            bit_idx_d = bit_idx_q + IDX_W'(1);
            if (run_left_q != '0) run_left_d = run_left_q - CNT_W'(1);
            if (bit_idx_q == IDX_W'(BYTE_W - 1)) out_reg_d = byte_buf_d;
         end
         S_FLUSH: begin
            out_reg_d = byte_buf_q;
            flush_d   = 1'b1;
         end
         S_COUNT_DONE: wr_req_d = send_ready;
         S_WAIT_OUT: begin
            bit_idx_d  = '0;
            byte_buf_d = '0;
         end
         default: ;
      endcase
   end

   assign rd_req   = rd_req_q;
   assign wr_req   = wr_req_q;
   assign out_data = out_reg_q;
   assign done     = done_q;

endmodule

// File: tb/tb_rle_dec.sv
// Directed bench for rle_dec: input/output FIFO models, table-driven run
// vectors, plus hand-written throttled-output and mid-run reset sequences.
module tb_rle_dec;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        recv_ready = 1'b0;
   logic [23:0] in_data = '0;
   logic        rd_req;
   logic        end_of_stream = 1'b0;
   logic        send_ready = 1'b1;
   logic [7:0]  out_data;
   logic        wr_req;
   logic        done;

   rle_dec #(.CNT_W(23), .BYTE_W(8)) dut (
      .clk(clk), .rst(rst), .recv_ready(recv_ready), .in_data(in_data),
      .rd_req(rd_req), .end_of_stream(end_of_stream), .send_ready(send_ready),
      .out_data(out_data), .wr_req(wr_req), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0][23:0] words;
      logic [2:0]       nw;
      logic [2:0][7:0]  exp;
      logic [2:0]       ne;
   } vec_t;

   int          passed = 0;
   int          total  = 0;
   logic [23:0] in_q[$];
   logic [7:0]  wr_q[$];
   int          rd_cnt = 0;
   logic        throttle = 1'b0;
   int          hold = 0;
   logic [7:0]  prev_out = '0;
   vec_t        vecs[9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   function automatic vec_t mk(input logic [23:0] w0, w1, w2, input logic [2:0] nw,
                               input logic [7:0] e0, e1, e2, input logic [2:0] ne);
      vec_t v;
      v.words = '0;
      v.words[0] = w0; v.words[1] = w1; v.words[2] = w2;
      v.nw = nw;
      v.exp = '0;
      v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2;
      v.ne = ne;
      return v;
   endfunction

   // FIFO models and per-write protocol checks, all on the falling edge.
   always @(negedge clk) begin
      if (!rst) begin
         if (wr_req) begin
            chk("wr_while_send_ready_low", {31'd0, send_ready}, 32'd1);
            chk("out_data_stable_into_wr", {24'd0, out_data}, {24'd0, prev_out});
            wr_q.push_back(out_data);
         end
         if (rd_req) begin
            rd_cnt++;
            if (in_q.size() > 0) in_data = in_q.pop_front();
         end
      end
      prev_out = out_data;
      if (throttle) begin
         if (wr_req) hold = 10;
         else if (hold > 0) hold--;
         send_ready = (hold == 0);
      end else begin
         send_ready = 1'b1;
      end
      recv_ready = (in_q.size() != 0);
   end

   task automatic start(input logic thr);
      rst = 1'b1;
      end_of_stream = 1'b0;
      in_q.delete();
      wr_q.delete();
      rd_cnt = 0;
      throttle = thr;
      hold = 10;
      repeat (2) @(negedge clk);
      chk("reset_outputs", {28'd0, rd_req, wr_req, done, |out_data}, 32'd0);
   endtask

   task automatic finish_vec(input string name, input vec_t v);
      for (int c = 0; c < 800 && !done; c++) @(negedge clk);
      chk({name, "_done"}, {31'd0, done}, 32'd1);
      repeat (3) @(negedge clk);
      chk({name, "_rd_count"}, rd_cnt, {29'd0, v.nw});
      chk({name, "_wr_count"}, wr_q.size(), {29'd0, v.ne});
      for (int i = 0; i < int'(v.ne); i++) begin
         if (i < wr_q.size())
            chk($sformatf("%s_byte%0d", name, i), {24'd0, wr_q[i]}, {24'd0, v.exp[i]});
         else
            chk($sformatf("%s_byte%0d", name, i), 32'hFFFF_FFFF, {24'd0, v.exp[i]});
      end
   endtask

   task automatic run_vec(input string name, input vec_t v, input logic thr);
      start(thr);
      for (int i = 0; i < int'(v.nw); i++) in_q.push_back(v.words[i]);
      recv_ready = (in_q.size() != 0);
      end_of_stream = 1'b1;
      rst = 1'b0;
      finish_vec(name, v);
   endtask

   initial begin
      vec_t v6;
      vecs[0] = mk(24'h800008, 24'h0, 24'h0, 3'd1, 8'hFF, 8'h00, 8'h00, 3'd1);
      vecs[1] = mk(24'h000003, 24'h800005, 24'h0, 3'd2, 8'hF8, 8'h00, 8'h00, 3'd1);
      vecs[2] = mk(24'h800003, 24'h0, 24'h0, 3'd1, 8'h07, 8'h00, 8'h00, 3'd1);
      vecs[3] = mk(24'h800004, 24'h000000, 24'h000004, 3'd3, 8'h0F, 8'h00, 8'h00, 3'd1);
      vecs[4] = mk(24'h0, 24'h0, 24'h0, 3'd0, 8'h00, 8'h00, 8'h00, 3'd0);
      vecs[5] = mk(24'h000005, 24'h800006, 24'h0, 3'd2, 8'hE0, 8'h07, 8'h00, 3'd2);
      vecs[6] = mk(24'h800001, 24'h000001, 24'h800001, 3'd3, 8'h05, 8'h00, 8'h00, 3'd1);
      vecs[7] = mk(24'h800009, 24'h0, 24'h0, 3'd1, 8'hFF, 8'h01, 8'h00, 3'd2);
      vecs[8] = mk(24'h00000C, 24'h0, 24'h0, 3'd1, 8'h00, 8'h00, 8'h00, 3'd2);

      for (int i = 0; i < 9; i++) run_vec($sformatf("vec%0d", i), vecs[i], 1'b0);

      // 20 ones with the output FIFO refusing each byte for 10 cycles.
      run_vec("throttled", mk(24'h800014, 24'h0, 24'h0, 3'd1, 8'hFF, 8'hFF, 8'h0F, 3'd3), 1'b1);

      // Reset in the middle of a long run, then decode a fresh word.
      start(1'b0);
      in_q.push_back(24'h800010);
      recv_ready = 1'b1;
      rst = 1'b0;
      for (int c = 0; c < 50 && rd_cnt == 0; c++) @(negedge clk);
      chk("midrun_rd_seen", rd_cnt, 32'd1);
      repeat (6) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midrun_reset_outputs", {28'd0, rd_req, wr_req, done, |out_data}, 32'd0);
      chk("midrun_no_write", wr_q.size(), 32'd0);
      in_q.delete();
      rd_cnt = 0;
      in_q.push_back(24'h000008);
      recv_ready = 1'b1;
      end_of_stream = 1'b1;
      rst = 1'b0;
      v6 = mk(24'h000008, 24'h0, 24'h0, 3'd1, 8'h00, 8'h00, 8'h00, 3'd1);
      finish_vec("after_reset", v6);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
